// File: rtl/sdram_clk_rst_seq_pkg.sv
// Shared types and helpers for the SDRAM clock/reset sequencer.
package sdram_clk_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_POWERUP   = 3'd3,
    ST_RUN       = 3'd4,
    ST_LOSS      = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  // Width of the shared cycle counter: enough to hold the largest (period - 1).
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sdram_clk_rst_seq_lock_sync_filter.sv
// PLL lock synchroniser (2 FF) followed by a run-length filter: lock_f_o rises
// after LOCK_FILT consecutive synchronised-high samples and drops on any low.
module lock_sync_filter #(
  parameter int LOCK_FILT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock_i,
  output logic lock_s_o,
  output logic lock_f_o
);

  localparam int FW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;

  logic [1:0]    sync_q;
  logic [FW-1:0] run_q, run_d;
  logic          lock_f_q, lock_f_d;

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], pll_lock_i};
  end

  assign lock_s_o = sync_q[1];

  // Run-length count; lock_f holds once reached until the next low sample.
  always_comb begin
    run_d    = run_q;
    lock_f_d = lock_f_q;
    if (!lock_s_o) begin
      run_d    = '0;
      lock_f_d = 1'b0;
    end else if (!lock_f_q) begin
      if (run_q == FW'(LOCK_FILT - 1)) lock_f_d = 1'b1;
      else                             run_d    = run_q + 1'b1;
    end
  end

  // Filter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= '0;
      lock_f_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      lock_f_q <= lock_f_d;
    end
  end

  assign lock_f_o = lock_f_q;

endmodule

// File: rtl/sdram_clk_rst_seq.sv
// SDRAM rPLL supervisor: drives PLL reset, qualifies lock, holds off the SDRAM
// reset until the clock is stable, times the power-up wait and retries/faults.
import sdram_clk_rst_seq_pkg::*;

module sdram_clk_rst_seq #(
  parameter  int PLL_RST_CYCLES = 16,
  parameter  int LOCK_TIMEOUT   = 27000,
  parameter  int LOCK_FILT      = 4,
  parameter  int STABLE_CYCLES  = 1024,
  parameter  int POWERUP_CYCLES = 5400,
  parameter  int MAX_RETRIES    = 3,
  localparam int RW             = $clog2(MAX_RETRIES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pll_lock,
  output logic          pll_reset,
  output logic          sdram_rst_n,
  output logic          powerup_done,
  output logic          relock_pulse,
  output logic [RW-1:0] retry_cnt,
  output logic          fault
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, POWERUP_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          lock_s, lock_f;
  logic          retry_fire;
  logic          pll_reset_q, pll_reset_d;
  logic          sdram_rst_n_q, sdram_rst_n_d;
  logic          powerup_done_q, powerup_done_d;
  logic          relock_q, relock_d;
  logic          fault_q, fault_d;

  lock_sync_filter #(.LOCK_FILT(LOCK_FILT)) u_lock (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock_i(pll_lock),
    .lock_s_o  (lock_s),
    .lock_f_o  (lock_f)
  );

  // Next state, shared counter, retry counter and next output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    retry_fire = 1'b0;
    unique case (state_q)
      ST_PLL_RST: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(PLL_RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A filter glitch never clears the counter: the timeout runs from entry.
        cnt_d = cnt_q + 1'b1;
        if (lock_f)                                state_d    = ST_STABLE;
        else if (cnt_q == CW'(LOCK_TIMEOUT - 1))   retry_fire = 1'b1;
      end
      ST_STABLE: begin
        cnt_d = cnt_q + 1'b1;
        if (!lock_s)                               retry_fire = 1'b1;
        else if (cnt_q == CW'(STABLE_CYCLES - 1))  state_d    = ST_POWERUP;
      end
      ST_POWERUP: begin
        cnt_d = cnt_q + 1'b1;
        if (!lock_s)                               state_d = ST_LOSS;
        else if (cnt_q == CW'(POWERUP_CYCLES - 1)) state_d = ST_RUN;
      end
      ST_RUN:   if (!lock_s) state_d = ST_LOSS;
      ST_LOSS:  state_d = ST_PLL_RST;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase

    // Retry decision: restart the PLL, or give up once the budget is spent.
    if (retry_fire) begin
      if (retry_q == RW'(MAX_RETRIES)) begin
        state_d = ST_FAULT;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = ST_PLL_RST;
      end
    end

    if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;
    if (state_d != state_q)                     cnt_d   = '0;

    // Outputs are registered from the next state so they line up with it.
    pll_reset_d    = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
    sdram_rst_n_d  = (state_d == ST_POWERUP) || (state_d == ST_RUN);
    powerup_done_d = (state_d == ST_RUN);
    relock_d       = (state_d == ST_LOSS);
    fault_d        = (state_d == ST_FAULT);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_PLL_RST;
      cnt_q          <= '0;
      retry_q        <= '0;
      pll_reset_q    <= 1'b1;
      sdram_rst_n_q  <= 1'b0;
      powerup_done_q <= 1'b0;
      relock_q       <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      pll_reset_q    <= pll_reset_d;
      sdram_rst_n_q  <= sdram_rst_n_d;
      powerup_done_q <= powerup_done_d;
      relock_q       <= relock_d;
      fault_q        <= fault_d;
    end
  end

  assign pll_reset    = pll_reset_q;
  assign sdram_rst_n  = sdram_rst_n_q;
  assign powerup_done = powerup_done_q;
  assign relock_pulse = relock_q;
  assign retry_cnt    = retry_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_sdram_clk_rst_seq.sv
// Bench for sdram_clk_rst_seq: stimulus pushes expected output-change events
// (cycle stamp + output vector); a monitor compares every observed change.
module tb_sdram_clk_rst_seq;

  typedef struct {
    int unsigned stamp;
    logic [6:0]  v;
  } exp_t;

  // Output vector: {pll_reset, sdram_rst_n, powerup_done, relock_pulse, fault, retry_cnt[1:0]}
  localparam logic [6:0] RSTV = 7'b1000000;
  localparam logic [6:0] IDLV = 7'b0000000;
  localparam logic [6:0] SDRV = 7'b0100000;
  localparam logic [6:0] RUNV = 7'b0110000;
  localparam logic [6:0] LOSV = 7'b0001000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset, sdram_rst_n, powerup_done, relock_pulse, fault;
  logic [1:0] retry_cnt;

  int unsigned cyc = 0;
  int unsigned compared = 0;
  int unsigned mismatched = 0;
  exp_t        expq[$];
  logic [6:0]  prev = 'x;
  logic [6:0]  cur;
  exp_t        e;
  logic        end_req = 1'b0;
  logic        end_ack = 1'b0;

  sdram_clk_rst_seq #(
    .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(50), .LOCK_FILT(4),
    .STABLE_CYCLES(16), .POWERUP_CYCLES(32), .MAX_RETRIES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .sdram_rst_n (sdram_rst_n),
    .powerup_done(powerup_done),
    .relock_pulse(relock_pulse),
    .retry_cnt   (retry_cnt),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output vector must match the next expected event.
  always @(negedge clk) begin
    cur = {pll_reset, sdram_rst_n, powerup_done, relock_pulse, fault, retry_cnt};
    if (cur !== prev) begin
      compared++;
      if (expq.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
      end else begin
        e = expq.pop_front();
        if (e.v !== cur || e.stamp != cyc) begin
          mismatched++;
          $display("FAIL event got cyc=%0d out=%b required cyc=%0d out=%b", cyc, cur, e.stamp, e.v);
        end
      end
      prev = cur;
    end
    if (end_req && !end_ack) begin
      compared++;
      if (expq.size() != 0) begin
        mismatched++;
        $display("FAIL missing_events got %0d pending required 0 (next cyc=%0d out=%b)",
                 expq.size(), expq[0].stamp, expq[0].v);
      end
      end_ack = 1'b1;
    end
  end

  task automatic push(input int unsigned s, input logic [6:0] v);
    exp_t x;
    x.stamp = s;
    x.v     = v;
    expq.push_back(x);
  endtask

  task automatic tick_to(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  int unsigned b, L, M, Q, R, S;

  initial begin
    // Power-on reset
    #1 rst_n = 1'b0;
    @(posedge clk); #2;
    push(cyc, RSTV);
    @(posedge clk); #2;
    rst_n = 1'b1;
    b = cyc;
    push(b + 4, IDLV);

    // Normal: lock 10 cycles after pll_reset falls
    tick_to(b + 14);
    L = cyc;
    pll_lock = 1'b1;
    push(L + 23, SDRV);
    push(L + 55, RUNV);

    // Loss in RUN: lock low for 2 cycles
    tick_to(L + 65);
    M = cyc;
    pll_lock = 1'b0;
    push(M + 3, LOSV);
    push(M + 4, RSTV);
    push(M + 8, IDLV);
    push(M + 25, SDRV);
    tick_to(M + 2);
    pll_lock = 1'b1;

    // Async reset mid-POWERUP, between clock edges
    tick_to(M + 35);
    push(cyc, RSTV);
    rst_n = 1'b0;
    tick_to(cyc + 2);
    rst_n = 1'b1;
    Q = cyc;
    push(Q + 4, IDLV);
    push(Q + 23, SDRV);
    push(Q + 55, RUNV);

    // Drop in STABLE: one low cycle, retry then full sequence, retry clears in RUN
    tick_to(Q + 60);
    push(cyc, RSTV);
    rst_n = 1'b0;
    tick_to(cyc + 2);
    rst_n = 1'b1;
    R = cyc;
    push(R + 4, IDLV);
    push(R + 13, 7'b1000001);
    push(R + 17, 7'b0000001);
    push(R + 34, 7'b0100001);
    push(R + 66, RUNV);
    tick_to(R + 10);
    pll_lock = 1'b0;
    tick_to(R + 11);
    pll_lock = 1'b1;

    // Glitch in WAIT_LOCK, then no lock: two retries, then sticky fault
    tick_to(R + 70);
    push(cyc, RSTV);
    rst_n = 1'b0;
    pll_lock = 1'b0;
    tick_to(cyc + 2);
    rst_n = 1'b1;
    S = cyc;
    push(S + 4, IDLV);
    push(S + 54, 7'b1000001);
    push(S + 58, 7'b0000001);
    push(S + 108, 7'b1000010);
    push(S + 112, 7'b0000010);
    push(S + 162, 7'b1000110);
    tick_to(S + 9);
    pll_lock = 1'b1;
    tick_to(S + 12);
    pll_lock = 1'b0;

    // Fault holds until rst_n
    tick_to(S + 260);
    push(cyc, RSTV);
    rst_n = 1'b0;
    tick_to(cyc + 3);

    end_req = 1'b1;
    tick_to(cyc + 3);
    if (!end_ack) begin
      $display("FAIL end_check got no ack required ack");
      $fatal(1, "monitor did not complete");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
